// File: rtl/generic_sram_pkg.sv
// Shared types and helpers for the 1R1W pipelined simulation SRAM.
package generic_sram_pkg;

  localparam int unsigned RD_LAT_MAX  = 4;
  localparam int unsigned MERGE_W_MAX = 256;

  typedef enum logic {
    S_INIT,
    S_READY
  } sram_state_e;

  // Lane-wise merge on words zero-extended to MERGE_W_MAX; callers slice back to their width.
  function automatic logic [MERGE_W_MAX-1:0] mask_merge(
    input logic [MERGE_W_MAX-1:0] old_word,
    input logic [MERGE_W_MAX-1:0] new_word,
    input logic [MERGE_W_MAX-1:0] mask,
    input int unsigned            lane_w
  );
    logic [MERGE_W_MAX-1:0] res;
    for (int unsigned i = 0; i < MERGE_W_MAX; i++) begin
      res[i] = mask[i / lane_w] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/generic_sram_rd_pipe.sv
// Read-data delay line: RD_LAT stages of {vld, data}; the last stage holds data between reads.
module generic_sram_rd_pipe #(
  parameter int unsigned W      = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [RD_LAT-1:0] vld_d, vld_q;
  logic [W-1:0]      data_d [RD_LAT];
  logic [W-1:0]      data_q [RD_LAT];

  // Each stage only captures on an incoming valid, so idle stages keep their last word.
  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_vld;
    data_d[0] = in_vld ? in_data : data_q[0];
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      data_q[i] <= data_d[i];
    end
    // Only the visible output word is cleared; inner stages are masked by their valids.
    if (rst) begin
      data_q[RD_LAT-1] <= '0;
    end else begin
      data_q[RD_LAT-1] <= data_d[RD_LAT-1];
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_data = data_q[RD_LAT-1];

endmodule

// File: rtl/generic_sram_1r1w_pipe.sv
// Simulation SRAM with one write and one read port, lane masks, pipelined reads and a clear sweep.
module generic_sram_1r1w_pipe
  import generic_sram_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned N          = 64,
  parameter int unsigned B          = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter bit          BYPASS     = 1'b0,
  parameter logic [W-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_busy,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic [W/B-1:0]       wr_mask,
  input  logic                 rd_en,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic                 rd_vld,
  output logic [W-1:0]         rd_data
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW:0] NWords = N[AW:0];

  if ((W % B) != 0) begin : g_bad_lane
    $error("W must be a multiple of B");
  end
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT out of range");
  end
  if (N < 2) begin : g_bad_depth
    $error("N must be at least 2");
  end
  if (W >= MERGE_W_MAX) begin : g_bad_width
    $error("W too wide for mask_merge");
  end

  sram_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [N];

  logic                   wr_acc, rd_acc, wr_in_range, rd_in_range;
  logic                   mem_we;
  logic [AW-1:0]          mem_waddr;
  logic [W-1:0]           mem_wdata;
  logic [W-1:0]           wr_old, wr_merged, rd_word;
  logic [MERGE_W_MAX-1:0] merge_full;
  logic                   unused_merge_hi;

  assign init_busy   = (state_q == S_INIT);
  assign wr_acc      = wr_en & ~init_busy;
  assign rd_acc      = rd_en & ~init_busy;
  assign wr_in_range = {1'b0, wr_addr} < NWords;
  assign rd_in_range = {1'b0, rd_addr} < NWords;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(N - 1)) begin
        state_d = S_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A collision implies equal addresses, so the write-path merge doubles as the bypass word.
  always_comb begin
    wr_old     = mem_q[wr_addr];
    merge_full = mask_merge(MERGE_W_MAX'(wr_old), MERGE_W_MAX'(wr_data),
                            MERGE_W_MAX'(wr_mask), B);
    wr_merged  = merge_full[W-1:0];

    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    if (init_busy) begin
      mem_we    = ~rst;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VALUE;
    end else if (wr_acc && wr_in_range) begin
      mem_we = ~rst;
    end

    rd_word = mem_q[rd_addr];
    if (BYPASS && wr_acc && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  assign unused_merge_hi = ^merge_full[MERGE_W_MAX-1:W];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  generic_sram_rd_pipe #(
    .W      (W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_acc),
    .in_data  (rd_word),
    .out_vld  (rd_vld),
    .out_data (rd_data)
  );

  wr_addr_in_range_a : assert property (@(posedge clk) disable iff (rst)
    !(wr_acc && !wr_in_range))
    else $error("write address out of range");
  rd_addr_in_range_a : assert property (@(posedge clk) disable iff (rst)
    !(rd_acc && !rd_in_range))
    else $error("read address out of range");

endmodule
